// File: rtl/merge_pkg.sv
// Shared definitions for the final merge stage.
// Holds the default widths, the data word type and the controller state encoding.
package merge_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_RUN_LEN = 16;
   localparam int DEF_ADDR_W  = 5;

   typedef logic [DEF_DATA_W-1:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MERGE  = 3'd1,
      ST_DRAIN1 = 3'd2,
      ST_DRAIN2 = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/merge_head_sel.sv
// Combinational head selector for the two sorted runs.
// Ports:
//   head1_i/head2_i   current head words of FIFO1/FIFO2
//   empty1_i/empty2_i FIFO has no valid head
//   exh1_i/exh2_i     run already fully consumed
//   sel1_o/sel2_o     take the head of FIFO1/FIFO2 this cycle (never both)
//   data_o            the selected head word
module merge_head_sel
   import merge_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] head1_i,
   input  logic [DATA_W-1:0] head2_i,
   input  logic              empty1_i,
   input  logic              empty2_i,
   input  logic              exh1_i,
   input  logic              exh2_i,
   output logic              sel1_o,
   output logic              sel2_o,
   output logic [DATA_W-1:0] data_o
);

   always_comb begin
      sel1_o = 1'b0;
      sel2_o = 1'b0;
      if (!exh1_i && !exh2_i) begin
         // Both runs live: wait for both heads, ties go to FIFO1 to keep the merge stable.
         if (!empty1_i && !empty2_i) begin
            if (head1_i <= head2_i) sel1_o = 1'b1;
            else                    sel2_o = 1'b1;
         end
      end else if (!exh1_i) begin
         sel1_o = !empty1_i;
      end else if (!exh2_i) begin
         sel2_o = !empty2_i;
      end
      data_o = sel2_o ? head2_i : head1_i;
   end

endmodule

// File: rtl/fifo_final_merge.sv
// Final 2-way merge of two ascending runs of RUN_LEN words into the register file.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 begins a merge from IDLE or DONE
//   fifoN_dout/empty      FWFT head word and empty flag of each run FIFO
//   fifoN_pop             active-low pop strobe (combinational)
//   mem_we/addr/wdata     registered register-file write port
//   done                  high from completion until the next accepted start
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_MERGE  | both runs live, comparing heads
// ST_DRAIN1 | run 2 consumed, copying the rest of run 1
// ST_DRAIN2 | run 1 consumed, copying the rest of run 2
// ST_DONE   | all words written, done held high
module fifo_final_merge
   import merge_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RUN_LEN = DEF_RUN_LEN,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] fifo1_dout,
   input  logic              fifo1_empty,
   output logic              fifo1_pop,
   input  logic [DATA_W-1:0] fifo2_dout,
   input  logic              fifo2_empty,
   output logic              fifo2_pop,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              done
);

   // One extra bit so the counters can hold RUN_LEN itself.
   localparam int CNT_W = $clog2(RUN_LEN) + 1;
   localparam logic [CNT_W-1:0] RUN_END = CNT_W'(RUN_LEN);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                done_q, done_d;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                exh1, exh2, sel1, sel2, pop_en, pop1, pop2;
   logic [DATA_W-1:0]   sel_data;

   assign exh1 = (cnt1_q == RUN_END);
   assign exh2 = (cnt2_q == RUN_END);

   merge_head_sel #(.DATA_W(DATA_W)) u_head_sel (
      .head1_i  (fifo1_dout),
      .head2_i  (fifo2_dout),
      .empty1_i (fifo1_empty),
      .empty2_i (fifo2_empty),
      .exh1_i   (exh1),
      .exh2_i   (exh2),
      .sel1_o   (sel1),
      .sel2_o   (sel2),
      .data_o   (sel_data)
   );

   assign pop_en    = (state_q == ST_MERGE) || (state_q == ST_DRAIN1) || (state_q == ST_DRAIN2);
   assign pop1      = pop_en && sel1;
   assign pop2      = pop_en && sel2;
   assign fifo1_pop = !pop1;
   assign fifo2_pop = !pop2;

   always_comb begin
      state_d   = state_q;
      cnt1_d    = cnt1_q;
      cnt2_d    = cnt2_q;
      wr_addr_d = wr_addr_q;
      done_d    = done_q;

      if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
      if (pop2) cnt2_d = cnt2_q + CNT_W'(1);
      if (pop1 || pop2) wr_addr_d = wr_addr_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_MERGE;
               cnt1_d    = '0;
               cnt2_d    = '0;
               wr_addr_d = '0;
               done_d    = 1'b0;
            end else if (state_q == ST_DONE) begin
               // Entering DONE coincides with the last write; done follows a cycle later.
               done_d = 1'b1;
            end
         end
         ST_MERGE: begin
            if (cnt1_d == RUN_END)      state_d = ST_DRAIN2;
            else if (cnt2_d == RUN_END) state_d = ST_DRAIN1;
         end
         ST_DRAIN1: if (cnt1_d == RUN_END) state_d = ST_DONE;
         ST_DRAIN2: if (cnt2_d == RUN_END) state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt1_q      <= '0;
         cnt2_q      <= '0;
         wr_addr_q   <= '0;
         done_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt1_q    <= cnt1_d;
         cnt2_q    <= cnt2_d;
         wr_addr_q <= wr_addr_d;
         done_q    <= done_d;
         mem_we_q  <= pop1 || pop2;
         if (pop1 || pop2) begin
            mem_addr_q  <= wr_addr_q;
            mem_wdata_q <= sel_data;
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fifo_final_merge.sv
module tb_fifo_final_merge;
   import merge_pkg::*;

   localparam int RL = DEF_RUN_LEN;
   localparam int NW = 2 * RL;

   logic                  clock, reset, start;
   word_t                 fifo1_dout, fifo2_dout;
   logic                  fifo1_empty, fifo2_empty, fifo1_pop, fifo2_pop;
   logic                  mem_we, done;
   logic [DEF_ADDR_W-1:0] mem_addr;
   word_t                 mem_wdata;

   fifo_final_merge dut (
      .clock(clock), .reset(reset), .start(start),
      .fifo1_dout(fifo1_dout), .fifo1_empty(fifo1_empty), .fifo1_pop(fifo1_pop),
      .fifo2_dout(fifo2_dout), .fifo2_empty(fifo2_empty), .fifo2_pop(fifo2_pop),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done)
   );

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    viol = 0;
   logic  stall2 = 1'b0;

   word_t q1[$], q2[$];
   int    src_log[$];
   int    waddr[$];
   word_t wdata[$];
   int    wcyc[$];
   word_t ra[RL], rb[RL];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc = cyc + 1;
   end

   // FWFT FIFO models: pops sampled mid-cycle, applied just after the edge.
   initial begin
      bit p1, p2;
      fifo1_empty = 1'b1; fifo2_empty = 1'b1;
      fifo1_dout = '0;    fifo2_dout = '0;
      forever begin
         @(negedge clock);
         p1 = !fifo1_pop;
         p2 = !fifo2_pop;
         @(posedge clock);
         #1;
         if (p1 && q1.size() > 0) begin void'(q1.pop_front()); src_log.push_back(1); end
         if (p2 && q2.size() > 0) begin void'(q2.pop_front()); src_log.push_back(2); end
         fifo1_empty = (q1.size() == 0);
         fifo1_dout  = fifo1_empty ? '0 : q1[0];
         fifo2_empty = (q2.size() == 0) || stall2;
         fifo2_dout  = (q2.size() == 0) ? '0 : q2[0];
      end
   end

   initial forever begin
      @(negedge clock);
      if (mem_we) begin
         waddr.push_back(int'(mem_addr));
         wdata.push_back(mem_wdata);
         wcyc.push_back(cyc);
      end
      if (!fifo1_pop && fifo1_empty) viol++;
      if (!fifo2_pop && fifo2_empty) viol++;
      if (!fifo1_pop && !fifo2_pop)  viol++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      src_log.delete(); waddr.delete(); wdata.delete(); wcyc.delete();
      viol = 0;
   endtask

   // Runs one full merge of ra/rb against a stable-sorted reference.
   task automatic do_run(input string tag, input int stall_at, input bit mid_start, input int extra2);
      word_t rv[NW];
      int    rs[NW];
      int    n, pos, e0, rel, delay;
      n = 0;
      for (int k = 0; k < NW; k++) begin
         word_t v;
         int    s;
         v = (k < RL) ? ra[k] : rb[k-RL];
         s = (k < RL) ? 1 : 2;
         pos = n;
         while (pos > 0 && rv[pos-1] > v) begin
            rv[pos] = rv[pos-1]; rs[pos] = rs[pos-1]; pos--;
         end
         rv[pos] = v; rs[pos] = s; n++;
      end

      q1.delete(); q2.delete();
      for (int i = 0; i < RL; i++) begin q1.push_back(ra[i]); q2.push_back(rb[i]); end
      for (int i = 0; i < extra2; i++) q2.push_back('0);
      clear_logs();
      @(negedge clock);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      e0 = cyc;
      @(negedge clock);
      start = 1'b0;
      chk({tag, "_done_low_after_start"}, done, 0);

      rel = 0;
      while (!done && rel < 300) begin
         @(negedge clock);
         rel = cyc - e0;
         if (stall_at > 0 && rel == stall_at - 1) stall2 = 1'b1;
         if (stall_at > 0 && rel == stall_at + 4) stall2 = 1'b0;
         if (mid_start && rel == 5) start = 1'b1;
         if (mid_start && rel == 6) start = 1'b0;
      end
      stall2 = 1'b0;
      start  = 1'b0;
      delay  = (stall_at > 0) ? 5 : 0;
      chk({tag, "_done_cycle"}, rel, 33 + delay);
      chk({tag, "_write_count"}, waddr.size(), NW);
      chk({tag, "_pop_count"}, src_log.size(), NW);
      for (int i = 0; i < NW && i < waddr.size(); i++) begin
         chk($sformatf("%s_addr[%0d]", tag, i), waddr[i], i);
         chk($sformatf("%s_data[%0d]", tag, i), wdata[i], rv[i]);
         chk($sformatf("%s_wcyc[%0d]", tag, i), wcyc[i] - e0,
             1 + i + ((stall_at > 0 && i >= stall_at) ? 5 : 0));
      end
      for (int i = 0; i < NW && i < src_log.size(); i++)
         chk($sformatf("%s_src[%0d]", tag, i), src_log[i], rs[i]);
      chk({tag, "_pop_violations"}, viol, 0);
      chk({tag, "_q1_left"}, q1.size(), 0);
      chk({tag, "_q2_left"}, q2.size(), extra2);
      @(negedge clock);
      chk({tag, "_we_low_in_done"}, mem_we, 0);
      chk({tag, "_done_held"}, done, 1);
   endtask

   task automatic rand_runs(input bit wide);
      word_t p1, p2;
      p1 = '0; p2 = '0;
      for (int i = 0; i < RL; i++) begin
         if (wide) begin
            ra[i] = (word_t'(i) << 28) | word_t'($urandom_range(0, 32'h0FFF_FFFF));
            rb[i] = (word_t'(i) << 28) | word_t'($urandom_range(0, 32'h0FFF_FFFF));
         end else begin
            p1 = p1 + word_t'($urandom_range(0, 3)); ra[i] = p1;
            p2 = p2 + word_t'($urandom_range(0, 3)); rb[i] = p2;
         end
      end
   endtask

   initial begin
      int k;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_done", done, 0);
      chk("rst_pop1", fifo1_pop, 1);
      chk("rst_pop2", fifo2_pop, 1);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);

      // Idle without start must not consume anything.
      for (int i = 0; i < RL; i++) begin q1.push_back(word_t'(i)); q2.push_back(word_t'(i)); end
      reset = 1'b0;
      repeat (5) @(negedge clock);
      chk("idle_q1", q1.size(), RL);
      chk("idle_q2", q2.size(), RL);
      chk("idle_we", mem_we, 0);

      for (int i = 0; i < RL; i++) begin ra[i] = word_t'(2*i); rb[i] = word_t'(2*i+1); end
      do_run("interleave", 0, 1'b0, 0);

      for (int i = 0; i < RL; i++) begin ra[i] = word_t'(100+i); rb[i] = word_t'(i); end
      do_run("disjoint", 0, 1'b0, 2);

      for (int i = 0; i < RL; i++) begin ra[i] = 32'h7; rb[i] = 32'h7; end
      do_run("ties", 0, 1'b0, 0);

      for (int i = 0; i < RL; i++) begin ra[i] = word_t'(2*i); rb[i] = word_t'(2*i+1); end
      do_run("stall", 5, 1'b0, 0);

      rand_runs(1'b0);
      do_run("rand_midstart", 0, 1'b1, 0);

      rand_runs(1'b1);
      do_run("rand_wide", 0, 1'b0, 0);

      // Reset in the middle of a merge.
      rand_runs(1'b0);
      q1.delete(); q2.delete();
      for (int i = 0; i < RL; i++) begin q1.push_back(ra[i]); q2.push_back(rb[i]); end
      clear_logs();
      repeat (2) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (waddr.size() < 10 && k < 60) begin @(negedge clock); k++; end
      chk("midrst_reached_10_writes", waddr.size() >= 10, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_we", mem_we, 0);
      chk("midrst_done", done, 0);
      chk("midrst_pop1", fifo1_pop, 1);
      chk("midrst_pop2", fifo2_pop, 1);
      reset = 1'b0;
      rand_runs(1'b0);
      do_run("after_reset", 0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
